// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the multi-channel PWM block.
//   - pwm_state_e       : sequencer state (IDLE / RUN / BURST_ON / BURST_OFF)
//   - PWM_PERIOD_W_DEF  : default period counter / duty compare width
//   - PWM_BURST_W_DEF   : default burst length width
//   - is_burst_state()  : true in either burst phase
package pwm_pkg;

   localparam int unsigned PWM_PERIOD_W_DEF = 16;
   localparam int unsigned PWM_BURST_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      BURST_ON  = 2'd2,
      BURST_OFF = 2'd3
   } pwm_state_e;

   function automatic logic is_burst_state(input pwm_state_e s);
      return (s == BURST_ON) || (s == BURST_OFF);
   endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// pwm_channel_cmp
//   One PWM channel: compares the shared period counter against this
//   channel's active duty and registers the result.
//   Ports:
//     SysClk  - system clock (rising edge)
//     Reset   - asynchronous active-low reset, forces PWM low
//     Enable  - channel enable, sampled every cycle
//     Gate    - sequencer gate (high while pulses may be produced)
//     Cnt     - shared period counter
//     Duty    - active high-time for this channel, in cycles
//     PWM     - registered channel output, one cycle behind Cnt
module pwm_channel_cmp
   import pwm_pkg::*;
#(
   parameter int unsigned PERIOD_W = PWM_PERIOD_W_DEF
) (
   input  logic                SysClk,
   input  logic                Reset,
   input  logic                Enable,
   input  logic                Gate,
   input  logic [PERIOD_W-1:0] Cnt,
   input  logic [PERIOD_W-1:0] Duty,
   output logic                PWM
);

   // Duty >= period yields a constant high because Cnt never reaches P.
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         PWM <= 1'b0;
      end else begin
         PWM <= Enable & Gate & (Cnt < Duty);
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi
//   Multi-channel PWM generator with a shared period counter, shadowed
//   (double-buffered) settings applied on period boundaries, and a burst
//   sequencer supporting one-shot and repeating gated bursts.
//   Ports:
//     SysClk     - system clock (rising edge)
//     Reset      - asynchronous active-low reset
//     Enable     - per-channel output enable
//     Period     - pending period in SysClk cycles (0 = stopped)
//     Duty       - pending per-channel high-time, channel i at [i*PERIOD_W +: PERIOD_W]
//     Burst      - pending burst-mode select (0 = continuous)
//     BurstType  - pending burst type (0 = one-shot, 1 = repeating gated)
//     BurstLen   - pending burst length in periods (0 treated as 1)
//     Load       - strobe capturing all pending inputs
//     Start      - strobe starting or stopping a burst
//     PWM        - registered PWM outputs
//     LoadAck    - pulse in the cycle the pending set is applied
//     PeriodEnd  - pulse on the last count of each running period
//     Busy       - high while a burst is in progress
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned PERIOD_W = PWM_PERIOD_W_DEF,
   parameter int unsigned BURST_W  = PWM_BURST_W_DEF
) (
   input  logic                       SysClk,
   input  logic                       Reset,
   input  logic [NUM_CH-1:0]          Enable,
   input  logic [PERIOD_W-1:0]        Period,
   input  logic [NUM_CH*PERIOD_W-1:0] Duty,
   input  logic                       Burst,
   input  logic                       BurstType,
   input  logic [BURST_W-1:0]         BurstLen,
   input  logic                       Load,
   input  logic                       Start,
   output logic [NUM_CH-1:0]          PWM,
   output logic                       LoadAck,
   output logic                       PeriodEnd,
   output logic                       Busy
);

   localparam int unsigned BW1 = BURST_W + 1;
   localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

   // Pending (shadow) set
   logic                       pend_q;
   logic [PERIOD_W-1:0]        pend_period_q;
   logic [NUM_CH*PERIOD_W-1:0] pend_duty_q;
   logic                       pend_burst_q;
   logic                       pend_type_q;
   logic [BURST_W-1:0]         pend_len_q;

   // Active set
   logic [PERIOD_W-1:0]        act_period_q;
   logic [NUM_CH*PERIOD_W-1:0] act_duty_q;
   logic                       act_burst_q;
   logic                       act_type_q;
   logic [BURST_W-1:0]         act_len_q;

   pwm_state_e                 state_q;
   pwm_state_e                 state_d;
   logic [PERIOD_W-1:0]        cnt_q;
   logic [BURST_W-1:0]         per_cnt_q;
   logic                       stop_q;

   logic                       running;
   logic                       wrap;
   logic                       apply;
   logic                       gate;
   logic                       stop_now;
   logic                       last_period;

   // Values seen by the state decision: when an apply coincides with a
   // boundary, the freshly applied set governs what happens next.
   logic [PERIOD_W-1:0]        eff_period;
   logic                       eff_burst;
   logic                       eff_type;
   logic [BURST_W-1:0]         eff_len;
   logic [BURST_W-1:0]         eff_len_nz;

   assign running    = (state_q != IDLE) && (act_period_q != '0);
   assign wrap       = running && (cnt_q == (act_period_q - CNT_ONE));
   assign apply      = pend_q && (wrap || (state_q == IDLE) || (act_period_q == '0));

   assign eff_period = apply ? pend_period_q : act_period_q;
   assign eff_burst  = apply ? pend_burst_q  : act_burst_q;
   assign eff_type   = apply ? pend_type_q   : act_type_q;
   assign eff_len    = apply ? pend_len_q    : act_len_q;
   assign eff_len_nz = (eff_len == '0) ? BURST_W'(1) : eff_len;

   // A Start sampled at the wrap itself stops the burst at that wrap.
   assign stop_now    = stop_q || Start;
   assign last_period = (BW1'(per_cnt_q) + BW1'(1)) >= BW1'(eff_len_nz);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (eff_burst) begin
               if (Start) begin
                  state_d = BURST_ON;
               end
            end else if (eff_period != '0) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // With P=0 there is no period in progress to finish.
            if (eff_burst && (wrap || (act_period_q == '0))) begin
               state_d = IDLE;
            end
         end
         BURST_ON: begin
            if (wrap) begin
               if (stop_now) begin
                  state_d = IDLE;
               end else if (last_period) begin
                  state_d = eff_type ? BURST_OFF : IDLE;
               end
            end else if (stop_now && (act_period_q == '0)) begin
               state_d = IDLE;
            end
         end
         BURST_OFF: begin
            if (wrap) begin
               if (stop_now) begin
                  state_d = IDLE;
               end else if (last_period) begin
                  state_d = BURST_ON;
               end
            end else if (stop_now && (act_period_q == '0)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      gate      = ((state_q == RUN) || (state_q == BURST_ON)) && (act_period_q != '0);
      Busy      = is_burst_state(state_q);
      PeriodEnd = wrap;
      LoadAck   = apply;
   end

   // ------------------------------------------------------------------
   // Period counter, burst period counter and pending stop request
   // ------------------------------------------------------------------
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         cnt_q     <= '0;
         per_cnt_q <= '0;
         stop_q    <= 1'b0;
      end else begin
         if (!running || wrap) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_ONE;
         end

         if (state_d != state_q) begin
            per_cnt_q <= '0;
         end else if (wrap && is_burst_state(state_q)) begin
            per_cnt_q <= per_cnt_q + BURST_W'(1);
         end

         if (state_d == IDLE) begin
            stop_q <= 1'b0;
         end else if (Start && is_burst_state(state_q)) begin
            stop_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Shadow capture and apply
   // ------------------------------------------------------------------
   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         pend_q        <= 1'b0;
         pend_period_q <= '0;
         pend_duty_q   <= '0;
         pend_burst_q  <= 1'b0;
         pend_type_q   <= 1'b0;
         pend_len_q    <= '0;
         act_period_q  <= '0;
         act_duty_q    <= '0;
         act_burst_q   <= 1'b0;
         act_type_q    <= 1'b0;
         act_len_q     <= BURST_W'(1);
      end else begin
         // A Load in the apply cycle refills the shadow for the next boundary.
         if (Load) begin
            pend_q        <= 1'b1;
            pend_period_q <= Period;
            pend_duty_q   <= Duty;
            pend_burst_q  <= Burst;
            pend_type_q   <= BurstType;
            pend_len_q    <= BurstLen;
         end else if (apply) begin
            pend_q <= 1'b0;
         end

         if (apply) begin
            act_period_q <= pend_period_q;
            act_duty_q   <= pend_duty_q;
            act_burst_q  <= pend_burst_q;
            act_type_q   <= pend_type_q;
            act_len_q    <= pend_len_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Channel compare / output registers
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel_cmp #(
         .PERIOD_W (PERIOD_W)
      ) u_ch (
         .SysClk (SysClk),
         .Reset  (Reset),
         .Enable (Enable[i]),
         .Gate   (gate),
         .Cnt    (cnt_q),
         .Duty   (act_duty_q[i*PERIOD_W +: PERIOD_W]),
         .PWM    (PWM[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi
//   Scoreboard bench for pwm_multi. Each scenario walks its timeline
//   period by period and pushes the expected outputs of every cycle; a
//   monitor on the falling edge pops and compares.
module tb_pwm_multi;

   localparam int NCH = 4;
   localparam int PW  = 16;
   localparam int BW  = 8;

   logic              SysClk = 1'b0;
   logic              Reset;
   logic [NCH-1:0]    Enable;
   logic [PW-1:0]     Period;
   logic [NCH*PW-1:0] Duty;
   logic              Burst;
   logic              BurstType;
   logic [BW-1:0]     BurstLen;
   logic              Load;
   logic              Start;
   logic [NCH-1:0]    PWM;
   logic              LoadAck;
   logic              PeriodEnd;
   logic              Busy;

   pwm_multi #(
      .NUM_CH   (NCH),
      .PERIOD_W (PW),
      .BURST_W  (BW)
   ) dut (
      .SysClk    (SysClk),
      .Reset     (Reset),
      .Enable    (Enable),
      .Period    (Period),
      .Duty      (Duty),
      .Burst     (Burst),
      .BurstType (BurstType),
      .BurstLen  (BurstLen),
      .Load      (Load),
      .Start     (Start),
      .PWM       (PWM),
      .LoadAck   (LoadAck),
      .PeriodEnd (PeriodEnd),
      .Busy      (Busy)
   );

   always #5 SysClk = ~SysClk;

   typedef struct {
      logic [NCH-1:0] pwm;
      logic           la;
      logic           pe;
      logic           busy;
   } exp_t;

   exp_t           sb_q[$];
   exp_t           mon_e;
   int             checks   = 0;
   int             failures = 0;
   int             n_push   = 0;
   int             n_pop    = 0;
   int             m_d[NCH];
   int             p_d[NCH];
   int             p_p;
   logic [NCH-1:0] pwm_carry;
   bit             force_en;
   bit             rnd_start;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge SysClk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_pop++;
         chk("pwm",       32'(PWM),       32'(mon_e.pwm));
         chk("loadack",   32'(LoadAck),   32'(mon_e.la));
         chk("periodend", 32'(PeriodEnd), 32'(mon_e.pe));
         chk("busy",      32'(Busy),      32'(mon_e.busy));
      end
   end

   // One cycle: cnt/gate describe where the period counter stands and
   // whether pulses are allowed; the PWM seen this cycle is the result
   // of the previous cycle's compare.
   task automatic tick(input int cnt, input bit gate, input bit busy, input bit pe, input bit la);
      exp_t e;
      Enable = force_en ? '1 : NCH'($urandom);
      e.pwm  = pwm_carry;
      e.la   = la;
      e.pe   = pe;
      e.busy = busy;
      sb_q.push_back(e);
      n_push++;
      for (int i = 0; i < NCH; i++) begin
         pwm_carry[i] = Enable[i] & gate & (cnt < m_d[i]);
      end
      @(posedge SysClk);
      #1;
      Load  = 1'b0;
      Start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_periods(input int p, input int n, input bit gate, input bit busy);
      for (int r = 0; r < n; r++) begin
         for (int k = 0; k < p; k++) begin
            if (rnd_start) Start = ($urandom_range(3, 0) == 0);
            tick(k, gate, busy, k == p - 1, 1'b0);
         end
      end
   endtask

   task automatic load_vals(input int p, input int d[NCH], input bit b, input bit bt, input int len);
      Period = PW'(p);
      for (int i = 0; i < NCH; i++) Duty[i*PW +: PW] = PW'(d[i]);
      Burst     = b;
      BurstType = bt;
      BurstLen  = BW'(len);
      Load      = 1'b1;
      p_p       = p;
      p_d       = d;
   endtask

   task automatic apply_model();
      m_d = p_d;
   endtask

   // Load cycle (still idle) followed by the LoadAck cycle.
   task automatic load_from_idle(input int p, input int d[NCH], input bit b, input bit bt, input int len);
      load_vals(p, d, b, bt, len);
      tick(0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(0, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_model();
   endtask

   task automatic do_reset(input bit chk_now);
      #1 Reset = 1'b0;
      #1;
      if (chk_now) begin
         chk("rst_pwm",       32'(PWM),       32'd0);
         chk("rst_busy",      32'(Busy),      32'd0);
         chk("rst_loadack",   32'(LoadAck),   32'd0);
         chk("rst_periodend", 32'(PeriodEnd), 32'd0);
      end
      Load  = 1'b0;
      Start = 1'b0;
      repeat (2) @(posedge SysClk);
      #1 Reset = 1'b1;
      pwm_carry = '0;
      for (int i = 0; i < NCH; i++) m_d[i] = 0;
   endtask

   task automatic rand_duty(input int p, output int d[NCH]);
      for (int i = 0; i < NCH; i++) d[i] = int'($urandom_range(p + 2, 0));
   endtask

   task automatic scen_cont(input int p, input int d[NCH], input bit en_all);
      do_reset(1'b1);
      force_en = en_all;
      load_from_idle(p, d, 1'b0, 1'b0, 1);
      rnd_start = 1'b1;
      run_periods(p, 3, 1'b1, 1'b0);
      rnd_start = 1'b0;
      force_en  = 1'b0;
   endtask

   task automatic scen_burst_once(input int p, input int d[NCH], input int len);
      do_reset(1'b1);
      load_from_idle(p, d, 1'b1, 1'b0, len);
      idle(2);
      Start = 1'b1;
      tick(0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_periods(p, (len == 0) ? 1 : len, 1'b1, 1'b1);
      idle(3);
   endtask

   task automatic scen_burst_rep(input int p, input int d[NCH], input int len, input bit stop_off);
      int l;
      int ks;
      bit g;
      l = (len == 0) ? 1 : len;
      do_reset(1'b1);
      load_from_idle(p, d, 1'b1, 1'b1, len);
      idle(1);
      Start = 1'b1;
      tick(0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         run_periods(p, l, 1'b1, 1'b1);
         run_periods(p, l, 1'b0, 1'b1);
      end
      if (stop_off) run_periods(p, l, 1'b1, 1'b1);
      g  = !stop_off;
      ks = int'($urandom_range(p - 1, 0));
      for (int k = 0; k < p; k++) begin
         if (k == ks) Start = 1'b1;
         tick(k, g, 1'b1, k == p - 1, 1'b0);
      end
      idle(3);
   endtask

   task automatic scen_midload(input int p, input int d[NCH], input int m,
                               input int p2, input int d2[NCH], input bit nb, input bit dbl);
      int k;
      int d3[NCH];
      do_reset(1'b1);
      load_from_idle(p, d, 1'b0, 1'b0, 1);
      run_periods(p, 2, 1'b1, 1'b0);
      for (k = 0; k < m; k++) tick(k, 1'b1, 1'b0, 1'b0, 1'b0);
      load_vals(p2, d2, nb, 1'b0, 1);
      tick(m, 1'b1, 1'b0, 1'b0, 1'b0);
      k = m + 1;
      if (dbl && (k <= p - 2)) begin
         rand_duty(12, d3);
         load_vals(int'($urandom_range(12, 1)), d3, nb, 1'b0, 1);
         tick(k, 1'b1, 1'b0, 1'b0, 1'b0);
         k++;
      end
      for (; k < p - 1; k++) tick(k, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(p - 1, 1'b1, 1'b0, 1'b1, 1'b1);
      apply_model();
      if (nb) idle(3);
      else run_periods(p_p, 2, 1'b1, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d[NCH];
      int d2[NCH];
      int p;
      int p2;

      Reset     = 1'b1;
      Enable    = '0;
      Period    = '0;
      Duty      = '0;
      Burst     = 1'b0;
      BurstType = 1'b0;
      BurstLen  = '0;
      Load      = 1'b0;
      Start     = 1'b0;
      pwm_carry = '0;
      force_en  = 1'b0;
      rnd_start = 1'b0;
      p_p       = 0;
      for (int i = 0; i < NCH; i++) begin
         m_d[i] = 0;
         p_d[i] = 0;
      end

      #1 Reset = 1'b0;
      #2;
      chk("init_pwm",       32'(PWM),       32'd0);
      chk("init_busy",      32'(Busy),      32'd0);
      chk("init_loadack",   32'(LoadAck),   32'd0);
      chk("init_periodend", 32'(PeriodEnd), 32'd0);
      @(posedge SysClk);
      #1 Reset = 1'b1;
      force_en = 1'b1;
      idle(4);
      force_en = 1'b0;

      // Continuous mode: fixed duty mix, then random settings
      d = '{0, 3, 10, 12};
      scen_cont(10, d, 1'b1);
      for (int n = 0; n < 4; n++) begin
         p = int'($urandom_range(12, 1));
         rand_duty(p, d);
         scen_cont(p, d, 1'b0);
      end

      // One-shot bursts
      d = '{4, 0, 2, 11};
      scen_burst_once(10, d, 3);
      for (int n = 0; n < 3; n++) begin
         p = int'($urandom_range(10, 1));
         rand_duty(p, d);
         scen_burst_once(p, d, int'($urandom_range(3, 0)));
      end

      // Repeating gated bursts with a stopping Start
      d = '{2, 5, 8, 1};
      scen_burst_rep(8, d, 2, 1'b0);
      for (int n = 0; n < 3; n++) begin
         p = int'($urandom_range(8, 2));
         rand_duty(p, d);
         scen_burst_rep(p, d, int'($urandom_range(3, 0)), n[0]);
      end

      // Shadow load in the middle of a running period
      d  = '{3, 1, 6, 9};
      d2 = '{7, 2, 0, 10};
      scen_midload(10, d, 5, 10, d2, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         p = int'($urandom_range(12, 2));
         rand_duty(p, d);
         p2 = int'($urandom_range(12, 1));
         rand_duty(p2, d2);
         scen_midload(p, d, int'($urandom_range(p - 2, 0)), p2, d2,
                      ($urandom_range(3, 0) == 0), n[0]);
      end

      // Zero period, then a real period
      do_reset(1'b1);
      force_en = 1'b1;
      d = '{1, 2, 3, 4};
      load_from_idle(0, d, 1'b0, 1'b0, 1);
      idle(10);
      d = '{1, 2, 3, 5};
      load_from_idle(4, d, 1'b0, 1'b0, 1);
      run_periods(4, 3, 1'b1, 1'b0);
      force_en = 1'b0;

      // Reset in the middle of a burst period
      do_reset(1'b1);
      force_en = 1'b1;
      d = '{8, 8, 8, 8};
      load_from_idle(10, d, 1'b1, 1'b0, 3);
      idle(1);
      Start = 1'b1;
      tick(0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) tick(k, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_reset_pwm",  32'(PWM),  32'hf);
      chk("pre_reset_busy", 32'(Busy), 32'd1);
      do_reset(1'b1);
      idle(15);
      force_en = 1'b0;

      chk("queue_drained", 32'(sb_q.size()), 32'd0);
      chk("push_pop",      32'(n_pop),       32'(n_push));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of output channels.
REQ-002 SHALL have parameter PERIOD_W, default 16, giving the period counter and duty compare width.
REQ-003 SHALL have parameter BURST_W, default 8, giving the burst length width.
REQ-004 SysClk  in  1  single system clock; all logic on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Enable  in  NUM_CH  per-channel output enable, sampled every cycle.
REQ-007 Period  in  PERIOD_W  pending period in SysClk cycles.
REQ-008 Duty  in  NUM_CH*PERIOD_W  pending per-channel high-time in cycles; channel i is at bits [i*PERIOD_W +: PERIOD_W].
REQ-009 Burst  in  1  pending burst-mode select (0 = continuous).
REQ-010 BurstType  in  1  pending burst type (0 = one-shot, 1 = repeating gated).
REQ-011 BurstLen  in  BURST_W  pending burst length in periods.
REQ-012 Load  in  1  one-cycle strobe that captures all pending inputs into the shadow set.
REQ-013 Start  in  1  one-cycle strobe that starts or stops a burst.
REQ-014 PWM  out  NUM_CH  registered PWM outputs.
REQ-015 LoadAck  out  1  one-cycle pulse when the shadow set becomes active.
REQ-016 PeriodEnd  out  1  one-cycle pulse on the last count of each period.
REQ-017 Busy  out  1  high while a burst is in progress.

Function
REQ-018 SHALL run a shared counter Cnt from 0 to P-1 and then wrap to 0; P is the active period.
REQ-019 P=0 SHALL hold Cnt at 0, drive all PWM low, and never assert PeriodEnd.
REQ-020 PWM[i] SHALL be registered as Enable[i] & Gate & (Cnt < D[i]), where D[i] is the active duty; output latency is 1 cycle after Cnt.
REQ-021 D[i]=0 SHALL give a constant low output; D[i]>=P SHALL give a constant high output while Gate is set.
REQ-022 PeriodEnd SHALL pulse in the cycle where Cnt==P-1 and the counter is running.
REQ-023 Load SHALL copy Period, Duty, Burst, BurstType and BurstLen into a pending set and set a pending flag; a second Load before apply SHALL overwrite the pending set.
REQ-024 The pending set SHALL become active at the next wrap (Cnt==P-1), or on the next cycle if the FSM is IDLE or P=0; LoadAck SHALL pulse once in the apply cycle.
REQ-025 A change to active values SHALL never truncate or extend a period already in progress.
REQ-026 BurstLen=0 SHALL be treated as 1.
REQ-027 FSM states SHALL be IDLE, RUN, BURST_ON and BURST_OFF.
REQ-028 IDLE transitions:
- Burst=0 and P!=0 -> RUN.
- Burst=1 and Start -> BURST_ON, with Cnt=0 on the next cycle.
- In IDLE, Cnt is held at 0.
REQ-029 RUN SHALL set Gate=1 continuously and SHALL go to IDLE at wrap if the active Burst becomes 1.
REQ-030 BURST_ON SHALL set Gate=1 and count periods at wrap; after BurstLen periods:
- BurstType 0 -> IDLE.
- BurstType 1 -> BURST_OFF.
REQ-031 BURST_OFF SHALL set Gate=0 with Cnt running, and SHALL go to BURST_ON after BurstLen periods.
REQ-032 Start during BURST_ON or BURST_OFF SHALL stop the burst at the next wrap, returning to IDLE; the current period SHALL complete.
REQ-033 Start in RUN SHALL be ignored.
REQ-034 If Start and a wrap occur in the same cycle, the burst SHALL stop at that wrap.
REQ-035 Busy SHALL be high in BURST_ON and BURST_OFF and low otherwise.
REQ-036 If Load-apply and a burst end coincide, the new values SHALL govern the next state decision.

Reset
REQ-037 Reset low SHALL immediately force:
- PWM=0, LoadAck=0, PeriodEnd=0, Busy=0.
- Cnt=0 and FSM=IDLE.
- Pending flag cleared.
- Active P=0 and all active D=0, Burst=0, BurstLen=1.
REQ-038 Reset asserted mid-burst SHALL abort the burst; after release the block SHALL wait for Load before producing any output.

Structure
REQ-039 Shared package pwm_pkg SHALL hold the FSM state enum and the default values of PERIOD_W and BURST_W.
REQ-040 Sub-module pwm_channel_cmp SHALL implement the per-channel compare and output register, instantiated NUM_CH times by a generate loop.

Verification
REQ-041 P=10, D={0,3,10,12}, Burst=0, Load, Enable=1111 -> PWM0 always low; PWM1 high 3 of every 10 cycles; PWM2 and PWM3 constant high.
REQ-042 P=10, D0=4, Burst=1, BurstType=0, BurstLen=3, Load then Start -> exactly 3 pulses of 4 cycles; Busy high for 30 cycles; then IDLE with PWM low.
REQ-043 P=8, D0=2, BurstType=1, BurstLen=2, Start -> 16 cycles with pulses, then 16 cycles low, repeating; a second Start -> IDLE at the next wrap.
REQ-044 RUN with P=10, D0=3; Load D0=7 at Cnt=5 -> the current period stays at 3 high cycles; LoadAck pulses once at wrap; the next period has 7 high cycles.
REQ-045 Reset low at cycle 5 of a burst period -> PWM and Busy go to 0 without a clock edge; after release all outputs stay low until a Load is applied.
REQ-046 Load with P=0 -> PWM all low and no PeriodEnd pulses; a subsequent Load with P=4 -> LoadAck pulses and PeriodEnd occurs every 4 cycles.
